// File: rtl/dma_pcie_c2h_axis_pkt_gen.sv
// C2H AXI-Stream packet generator: one command at a time, incrementing 32-bit lane pattern.
// Optional per-byte parity on c2h_tparity when DMA_C2H_PARITY_GEN_EN is defined.
module dma_pcie_c2h_axis_pkt_gen #(
  parameter int MAX_LEN = 4096
) (
  input  logic         user_clk,
  input  logic         user_reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [15:0]  cmd_len,
  input  logic [10:0]  cmd_qid,
  input  logic [31:0]  cmd_seed,
  output logic [511:0] c2h_tdata,
  output logic [63:0]  c2h_tparity,
  output logic [63:0]  c2h_tkeep,
  output logic         c2h_tlast,
  output logic         c2h_tvalid,
  output logic [63:0]  c2h_tusr,
  input  logic         c2h_tready,
  output logic         pkt_done,
  output logic         cmd_err,
  output logic [31:0]  pkt_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [511:0]  tdata_q, tdata_d;
  logic [63:0]   tkeep_q, tkeep_d;
  logic [63:0]   tusr_q, tusr_d;
  logic [5:0]    k_q, k_d;
  logic [5:0]    last_k_q, last_k_d;
  logic [5:0]    rem_q, rem_d;
  logic          pkt_done_q, pkt_done_d;
  logic          cmd_err_q, cmd_err_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;

  logic hs, fin, acc, len_ok;

  function automatic logic [63:0] keep_mask(input logic [5:0] r);
    if (r == 6'd0) return '1;
    return (64'd1 << r) - 64'd1;
  endfunction

  assign hs     = (state_q == SEND) & c2h_tready;
  assign fin    = hs & tlast_q;
  // Ready is raised in the final-beat handshake cycle so a waiting command chains without a bubble.
  assign cmd_ready = ready_q | fin;
  assign acc    = cmd_valid & cmd_ready;
  assign len_ok = (cmd_len != 16'd0) && (cmd_len <= 16'(MAX_LEN));

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tusr_d     = tusr_q;
    k_d        = k_q;
    last_k_d   = last_k_q;
    rem_d      = rem_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;
    cmd_err_d  = 1'b0;

    if (state_q == IDLE) ready_d = 1'b1;

    if (fin) begin
      pkt_done_d = 1'b1;
      pkt_cnt_d  = pkt_cnt_q + 32'd1;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      state_d    = IDLE;
      ready_d    = 1'b1;
    end else if (hs) begin
      k_d = k_q + 6'd1;
      for (int w = 0; w < 16; w++)
        tdata_d[32*w +: 32] = tdata_q[32*w +: 32] + 32'd16;
      tlast_d = (k_d == last_k_q);
      tkeep_d = tlast_d ? keep_mask(rem_q) : '1;
    end

    if (acc) begin
      if (len_ok) begin
        state_d  = SEND;
        ready_d  = 1'b0;
        tvalid_d = 1'b1;
        k_d      = 6'd0;
        last_k_d = 6'((cmd_len - 16'd1) >> 6);
        rem_d    = cmd_len[5:0];
        for (int w = 0; w < 16; w++)
          tdata_d[32*w +: 32] = cmd_seed + 32'(w);
        tlast_d  = (last_k_d == 6'd0);
        tkeep_d  = tlast_d ? keep_mask(cmd_len[5:0]) : '1;
        // Sequence number is the count after any completion in this same cycle.
        tusr_d   = {pkt_cnt_d, 5'd0, cmd_len, cmd_qid};
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tusr_q     <= '0;
      k_q        <= '0;
      last_k_q   <= '0;
      rem_q      <= '0;
      pkt_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tusr_q     <= tusr_d;
      k_q        <= k_d;
      last_k_q   <= last_k_d;
      rem_q      <= rem_d;
      pkt_done_q <= pkt_done_d;
      cmd_err_q  <= cmd_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

`ifdef DMA_C2H_PARITY_GEN_EN
  logic [63:0] tparity_q, tparity_d;

  always_comb begin
    tparity_d = '0;
    for (int i = 0; i < 64; i++)
      tparity_d[i] = ^tdata_d[8*i +: 8];
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) tparity_q <= '0;
    else            tparity_q <= tparity_d;
  end

  assign c2h_tparity = tparity_q;
`else
  assign c2h_tparity = '0;
`endif

  assign c2h_tdata  = tdata_q;
  assign c2h_tkeep  = tkeep_q;
  assign c2h_tlast  = tlast_q;
  assign c2h_tvalid = tvalid_q;
  assign c2h_tusr   = tusr_q;
  assign pkt_done   = pkt_done_q;
  assign cmd_err    = cmd_err_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_dma_pcie_c2h_axis_pkt_gen.sv
// Directed + randomized bench for the C2H packet generator against a per-beat pattern model.
module tb_dma_pcie_c2h_axis_pkt_gen;
  logic         user_clk = 1'b0;
  logic         user_reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [15:0]  cmd_len = '0;
  logic [10:0]  cmd_qid = '0;
  logic [31:0]  cmd_seed = '0;
  logic [511:0] c2h_tdata;
  logic [63:0]  c2h_tparity, c2h_tkeep, c2h_tusr;
  logic         c2h_tlast, c2h_tvalid;
  logic         c2h_tready = 1'b1;
  logic         pkt_done, cmd_err;
  logic [31:0]  pkt_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = '0;
  logic [15:0] q_len[$];
  logic [10:0] q_qid[$];
  logic [31:0] q_seed[$];

  dma_pcie_c2h_axis_pkt_gen dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_qid(cmd_qid), .cmd_seed(cmd_seed),
    .c2h_tdata(c2h_tdata), .c2h_tparity(c2h_tparity), .c2h_tkeep(c2h_tkeep),
    .c2h_tlast(c2h_tlast), .c2h_tvalid(c2h_tvalid), .c2h_tusr(c2h_tusr),
    .c2h_tready(c2h_tready), .pkt_done(pkt_done), .cmd_err(cmd_err),
    .pkt_cnt(pkt_cnt)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_data(input logic [31:0] seed, input int k);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = seed + 32'(16*k + w);
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int len, input int k);
    logic [63:0] m;
    int nb, r;
    nb = (len + 63) / 64;
    r  = len % 64;
    m  = '1;
    if (k == nb - 1 && r != 0) begin
      m = '0;
      for (int b = 0; b < r; b++) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [63:0] exp_par(input logic [511:0] d);
    logic [63:0] p;
    p = '0;
`ifdef DMA_C2H_PARITY_GEN_EN
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
`endif
    return p;
  endfunction

  task automatic push(input logic [15:0] len, input logic [10:0] qid, input logic [31:0] seed);
    q_len.push_back(len); q_qid.push_back(qid); q_seed.push_back(seed);
  endtask

  // Sends all queued commands, chaining each onto the previous packet's final handshake.
  // mode 0: tready=1, mode 1: tready 1,0,0 repeating, mode 2: random tready.
  task automatic stream(input int mode);
    int n, idx, k, nb, cyc, p;
    logic tr, last;
    logic [31:0] seq;
    n = q_len.size(); idx = 0; k = 0; cyc = 0; p = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = q_len[0]; cmd_qid = q_qid[0]; cmd_seed = q_seed[0];
    @(negedge user_clk);
    cmd_valid = 1'b0;
    nb = (q_len[0] + 63) / 64;
    seq = exp_cnt;
    while (idx < n && cyc < 3000) begin
      last = (k == nb - 1);
      chk("tvalid", c2h_tvalid, 1);
      chk("tdata", c2h_tdata, exp_data(q_seed[idx], k));
      chk("tkeep", c2h_tkeep, exp_keep(int'(q_len[idx]), k));
      chk("tlast", c2h_tlast, last);
      chk("tusr", c2h_tusr, {seq, 5'd0, q_len[idx], q_qid[idx]});
      chk("tparity", c2h_tparity, exp_par(exp_data(q_seed[idx], k)));
      case (mode)
        0:       tr = 1'b1;
        1:       tr = (p % 3 == 0);
        default: tr = 1'($urandom_range(0, 1));
      endcase
      p++;
      c2h_tready = tr;
      if (tr && last && idx + 1 < n) begin
        cmd_valid = 1'b1; cmd_len = q_len[idx+1]; cmd_qid = q_qid[idx+1]; cmd_seed = q_seed[idx+1];
      end
      #1;
      chk("cmd_ready_send", cmd_ready, tr && last);
      @(negedge user_clk);
      cmd_valid = 1'b0;
      cyc++;
      chk("pkt_done", pkt_done, tr && last);
      if (tr) begin
        if (last) begin
          exp_cnt++;
          chk("pkt_cnt", pkt_cnt, exp_cnt);
          idx++;
          k = 0;
          seq = exp_cnt;
          if (idx < n) nb = (q_len[idx] + 63) / 64;
        end else k++;
      end
    end
    chk("stream_timeout", cyc < 3000, 1);
    chk("tvalid_end", c2h_tvalid, 0);
    q_len.delete(); q_qid.delete(); q_seed.delete();
    c2h_tready = 1'b1;
  endtask

  task automatic bad_cmd(input logic [15:0] len);
    cmd_valid = 1'b1; cmd_len = len; cmd_qid = 11'd3; cmd_seed = 32'h1234;
    @(negedge user_clk);
    cmd_valid = 1'b0;
    chk("cmd_err_pulse", cmd_err, 1);
    chk("cmd_err_tvalid", c2h_tvalid, 0);
    chk("cmd_err_ready", cmd_ready, 1);
    @(negedge user_clk);
    chk("cmd_err_clear", cmd_err, 0);
    chk("cmd_err_tvalid2", c2h_tvalid, 0);
    chk("cmd_err_cnt", pkt_cnt, exp_cnt);
  endtask

  initial begin
    logic [31:0] s;
    repeat (2) @(negedge user_clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_tvalid", c2h_tvalid, 0);
    chk("rst_tlast", c2h_tlast, 0);
    chk("rst_tdata", c2h_tdata, 0);
    chk("rst_tkeep", c2h_tkeep, 0);
    chk("rst_tusr", c2h_tusr, 0);
    chk("rst_tparity", c2h_tparity, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_cnt", pkt_cnt, 0);
    user_reset = 1'b0;
    @(negedge user_clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_tvalid", c2h_tvalid, 0);

    push(16'd64, 11'd5, 32'h0);
    stream(0);
    push(16'd130, 11'd9, 32'hFFFF_FFF0);
    stream(0);
    push(16'd256, 11'd17, $urandom);
    stream(1);
    push(16'd100, 11'd1, $urandom);
    push(16'd200, 11'd2, $urandom);
    stream(0);

    bad_cmd(16'd0);
    bad_cmd(16'd4097);

    for (int i = 0; i < 6; i++)
      push(16'($urandom_range(1, 700)), 11'($urandom), $urandom);
    stream(2);
    push(16'd4096, 11'h7FF, $urandom);
    push(16'd1, 11'd0, $urandom);
    stream(0);

    // Reset while beat 2 of a 5-beat packet is on the bus.
    s = $urandom;
    cmd_valid = 1'b1; cmd_len = 16'd300; cmd_qid = 11'd7; cmd_seed = s;
    @(negedge user_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge user_clk);
    chk("pre_rst_beat2", c2h_tdata, exp_data(s, 2));
    user_reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", c2h_tvalid, 0);
    chk("mid_rst_tlast", c2h_tlast, 0);
    chk("mid_rst_cnt", pkt_cnt, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    @(negedge user_clk);
    user_reset = 1'b0;
    exp_cnt = '0;
    @(negedge user_clk);
    push(16'd300, 11'd7, $urandom);
    stream(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
